// File: rtl/hazard_scoreboard.sv
// Load-use hazard detector beside ID: per-register countdown of not-yet-forwardable
// results, combinational stall, saturating stall statistic and sticky stuck-stall watchdog.
module hazard_scoreboard #(
    parameter int unsigned NUM_REGS      = 8,
    parameter int unsigned REG_W         = 3,
    parameter int unsigned LOAD_LAT      = 1,
    parameter int unsigned ALU_LAT       = 0,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STALL_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_W-1:0]    id_rs,
    input  logic                id_rs_used,
    input  logic [REG_W-1:0]    id_rd,
    input  logic                id_rd_used,
    input  logic                id_reg_write,
    input  logic                id_mem_read,
    input  logic                flush,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic [CNT_W-1:0]    stall_count,
    output logic                stall_err
);

    localparam int unsigned LAT_W = $clog2(LOAD_LAT + 1);
    localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);

    logic [LAT_W-1:0] r_cnt [NUM_REGS];
    logic [RUN_W-1:0] r_run;
    logic [CNT_W-1:0] r_stall_count;
    logic             r_stall_err;

    logic             w_rs_pend;
    logic             w_rd_pend;
    logic             w_issue;
    logic [RUN_W-1:0] w_run_nxt;

    // Hazard check uses the pre-edge counters; a rs==rd pair just checks the same entry twice.
    assign w_rs_pend = id_rs_used && (r_cnt[id_rs] != '0);
    assign w_rd_pend = id_rd_used && (r_cnt[id_rd] != '0);
    assign stall     = id_valid && !flush && (w_rs_pend || w_rd_pend);
    assign w_issue   = id_valid && !flush && !stall;

    always_comb begin
        w_run_nxt = '0;
        if (stall) begin
            if (r_run == RUN_W'(STALL_TIMEOUT))
                w_run_nxt = r_run;
            else
                w_run_nxt = r_run + RUN_W'(1);
        end
    end

    always_comb begin
        pending = '0;
        for (int r = 0; r < NUM_REGS; r++)
            pending[r] = (r_cnt[r] != '0);
    end

    // Youngest issuing writer reloads its counter; everything else drains toward zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                r_cnt[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                if (w_issue && id_reg_write && (id_rd == REG_W'(r)))
                    r_cnt[r] <= id_mem_read ? LAT_W'(LOAD_LAT) : LAT_W'(ALU_LAT);
                else if (r_cnt[r] != '0)
                    r_cnt[r] <= r_cnt[r] - LAT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= '0;
            r_run         <= '0;
            r_stall_err   <= 1'b0;
        end else begin
            if (stall && (r_stall_count != '1))
                r_stall_count <= r_stall_count + CNT_W'(1);
            r_run <= w_run_nxt;
            if (w_run_nxt == RUN_W'(STALL_TIMEOUT))
                r_stall_err <= 1'b1;
        end
    end

    assign stall_count = r_stall_count;
    assign stall_err   = r_stall_err;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: three parameter variants share one stimulus bus,
// directed vectors push hand-computed expectations, a negedge monitor pops and compares.
module tb_hazard_scoreboard;

    typedef struct {
        int          sel;
        logic        stall;
        logic [7:0]  pend;
        logic [15:0] cnt;
        logic        err;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    logic       clk;
    logic       rst_a, rst_b, rst_c;
    int         sel, nsel;
    logic       v, rsu, rdu, wr, mem, fl;
    logic [2:0] rs, rd;

    logic        st_a, st_b, st_c, er_a, er_b, er_c;
    logic [7:0]  pd_a, pd_b, pd_c;
    logic [15:0] sc_a, sc_c;
    logic [3:0]  sc_b;

    // A: LOAD_LAT=1 defaults; B: LOAD_LAT=3, 4-bit count, timeout 4; C: LOAD_LAT=5, timeout 4.
    hazard_scoreboard #(.LOAD_LAT(1), .ALU_LAT(0), .CNT_W(16), .STALL_TIMEOUT(64)) u_a (
        .clk(clk), .reset(rst_a), .id_valid(v && sel == 0), .id_rs(rs), .id_rs_used(rsu),
        .id_rd(rd), .id_rd_used(rdu), .id_reg_write(wr), .id_mem_read(mem), .flush(fl),
        .stall(st_a), .pending(pd_a), .stall_count(sc_a), .stall_err(er_a));

    hazard_scoreboard #(.LOAD_LAT(3), .ALU_LAT(0), .CNT_W(4), .STALL_TIMEOUT(4)) u_b (
        .clk(clk), .reset(rst_b), .id_valid(v && sel == 1), .id_rs(rs), .id_rs_used(rsu),
        .id_rd(rd), .id_rd_used(rdu), .id_reg_write(wr), .id_mem_read(mem), .flush(fl),
        .stall(st_b), .pending(pd_b), .stall_count(sc_b), .stall_err(er_b));

    hazard_scoreboard #(.LOAD_LAT(5), .ALU_LAT(0), .CNT_W(16), .STALL_TIMEOUT(4)) u_c (
        .clk(clk), .reset(rst_c), .id_valid(v && sel == 2), .id_rs(rs), .id_rs_used(rsu),
        .id_rd(rd), .id_rd_used(rdu), .id_reg_write(wr), .id_mem_read(mem), .flush(fl),
        .stall(st_c), .pending(pd_c), .stall_count(sc_c), .stall_err(er_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: pops one expectation per cycle that has one and compares the selected DUT.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t        e;
            logic        a_st, a_er;
            logic [7:0]  a_pd;
            logic [15:0] a_sc;
            e = q.pop_front();
            case (e.sel)
                0:       begin a_st = st_a; a_pd = pd_a; a_sc = sc_a;        a_er = er_a; end
                1:       begin a_st = st_b; a_pd = pd_b; a_sc = 16'(sc_b);   a_er = er_b; end
                default: begin a_st = st_c; a_pd = pd_c; a_sc = sc_c;        a_er = er_c; end
            endcase
            n_vec++;
            if (a_st !== e.stall || a_pd !== e.pend || a_sc !== e.cnt || a_er !== e.err) begin
                n_bad++;
                $display("FAIL %s: got stall=%b pending=%h count=%0d err=%b, want stall=%b pending=%h count=%0d err=%b",
                         e.name, a_st, a_pd, a_sc, a_er, e.stall, e.pend, e.cnt, e.err);
            end
        end
    end

    task automatic drive(input logic iv, input logic [2:0] irs, input logic irsu,
                         input logic [2:0] ird, input logic irdu, input logic iwr,
                         input logic imem, input logic ifl);
        @(posedge clk);
        #1;
        sel = nsel;
        v = iv; rs = irs; rsu = irsu; rd = ird; rdu = irdu; wr = iwr; mem = imem; fl = ifl;
    endtask

    task automatic chk(input logic est, input logic [7:0] epd, input int ecnt,
                       input logic eer, input string nm);
        exp_t e;
        e.sel = sel; e.stall = est; e.pend = epd; e.cnt = 16'(ecnt); e.err = eer; e.name = nm;
        q.push_back(e);
    endtask

    task automatic idle();                      drive(0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic load(input logic [2:0] r);   drive(1, 0, 0, r, 0, 1, 1, 0); endtask
    task automatic alu_wr(input logic [2:0] r); drive(1, 0, 0, r, 0, 1, 0, 0); endtask
    task automatic use_rs(input logic [2:0] r); drive(1, r, 1, 0, 0, 0, 0, 0); endtask
    task automatic use_rd(input logic [2:0] r); drive(1, 0, 0, r, 1, 0, 0, 0); endtask

    initial begin
        rst_a = 1; rst_b = 1; rst_c = 1;
        sel = 0; nsel = 0;
        v = 0; rs = 0; rsu = 0; rd = 0; rdu = 0; wr = 0; mem = 0; fl = 0;

        idle();
        drive(1, 3, 1, 3, 1, 0, 0, 0); chk(0, 8'h00, 0, 0, "reset_state");
        idle(); rst_a = 0; rst_b = 0; rst_c = 0;

        // LOAD_LAT=1: one bubble after a load, same-reg operands, own-destination rewrite.
        load(3);              chk(0, 8'h00, 0, 0, "a_load_r3");
        use_rs(3);            chk(1, 8'h08, 0, 0, "a_use_r3_bubble");
        use_rs(3);            chk(0, 8'h00, 1, 0, "a_use_r3_issue");
        idle();               chk(0, 8'h00, 1, 0, "a_idle_after");
        load(6);              chk(0, 8'h00, 1, 0, "a_load_r6");
        drive(1, 6, 1, 6, 1, 0, 0, 0); chk(1, 8'h40, 1, 0, "a_same_rs_rd_stall");
        drive(1, 6, 1, 6, 1, 0, 0, 0); chk(0, 8'h00, 2, 0, "a_same_rs_rd_issue");
        load(2);              chk(0, 8'h00, 2, 0, "a_load_r2");
        load(2);              chk(0, 8'h04, 2, 0, "a_own_dest_no_stall");
        idle();               chk(0, 8'h04, 2, 0, "a_r2_reloaded");
        idle();               chk(0, 8'h00, 2, 0, "a_r2_drained");

        // LOAD_LAT=3 variant.
        nsel = 1;
        load(5);              chk(0, 8'h00, 0, 0, "b_load_r5");
        use_rd(5);            chk(1, 8'h20, 0, 0, "b_rd_stall1");
        use_rd(5);            chk(1, 8'h20, 1, 0, "b_rd_stall2");
        use_rd(5);            chk(1, 8'h20, 2, 0, "b_rd_stall3");
        use_rd(5);            chk(0, 8'h00, 3, 0, "b_rd_issue");
        load(5);              chk(0, 8'h00, 3, 0, "b_load_r5_again");
        use_rs(2);            chk(0, 8'h20, 3, 0, "b_independent_r2");
        idle();               chk(0, 8'h20, 3, 0, "b_r5_draining");
        idle();
        idle();               chk(0, 8'h00, 3, 0, "b_r5_drained");
        load(4);              chk(0, 8'h00, 3, 0, "b_load_r4");
        alu_wr(4);            chk(0, 8'h10, 3, 0, "b_alu_overwrites_r4");
        use_rs(4);            chk(0, 8'h00, 3, 0, "b_r4_reader_no_stall");
        load(3);              chk(0, 8'h00, 3, 0, "b_load_r3");
        use_rs(3);            chk(1, 8'h08, 3, 0, "b_r3_stall");
        drive(1, 3, 1, 0, 0, 0, 0, 1); chk(0, 8'h08, 4, 0, "b_flush_mid_stall");
        use_rs(3);            chk(1, 8'h08, 4, 0, "b_after_flush_stall");
        use_rs(3);            chk(0, 8'h00, 5, 0, "b_after_flush_issue");
        for (int k = 0; k < 4; k++) begin
            load(7);
            for (int j = 0; j < 4; j++) use_rs(7);
        end
        idle();               chk(0, 8'h00, 15, 0, "b_count_saturated");

        // LOAD_LAT=5 variant: watchdog and async reset mid-stall.
        nsel = 2;
        load(1);              chk(0, 8'h00, 0, 0, "c_load_r1");
        use_rs(1);            chk(1, 8'h02, 0, 0, "c_stall_edge0");
        use_rs(1);            chk(1, 8'h02, 1, 0, "c_stall_edge1");
        use_rs(1);            chk(1, 8'h02, 2, 0, "c_stall_edge2");
        use_rs(1);            chk(1, 8'h02, 3, 0, "c_stall_edge3");
        use_rs(1);            chk(1, 8'h02, 4, 1, "c_watchdog_fired");
        use_rs(1);            chk(0, 8'h00, 5, 1, "c_err_sticky_issue");
        idle();               chk(0, 8'h00, 5, 1, "c_err_sticky_idle");
        load(1);              chk(0, 8'h00, 5, 1, "c_load_r1_again");
        use_rs(1);            chk(1, 8'h02, 5, 1, "c_stall_before_reset");
        use_rs(1); rst_c = 1; chk(0, 8'h00, 0, 0, "c_reset_mid_stall");
        use_rs(1); rst_c = 0; chk(0, 8'h00, 0, 0, "c_after_reset");
        idle();

        for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
